// File: rtl/wb_sram_bist_master.sv
// Wishbone classic initiator that runs a write/read-back test over an SRAM
// responder. A start pulse writes P(i) = seed + i to A(i) = ADDR_BASE + 4*i for
// every word, reads each word back and compares it against the same pattern,
// then reports pass/fail, a saturating mismatch count and the first failing address.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   start_i, seed_i         start request (honoured in IDLE/DONE) and pattern seed
//   wbm_*                   Wishbone classic initiator port
//   busy_o, done_o, pass_o  run status; pass_o only meaningful while done_o=1
//   timeout_o               run aborted because the responder stopped acking
//   err_count_o             mismatch count, saturating at 16'hFFFF
//   fail_adr_o              byte address of the first mismatch, 0 if none
module wb_sram_bist_master #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int unsigned WORDS     = 1024,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_count_o,
  output logic [31:0] fail_adr_o
);

  typedef enum logic [2:0] {StIdle, StWrite, StWgap, StRead, StRgap, StDone} state_e;

  localparam logic [9:0]  LastIdx  = 10'(WORDS - 1);
  // Aborting when the counter is at TIMEOUT-1 and this cycle also stalls makes
  // stb stay high for exactly TIMEOUT unacknowledged cycles.
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] err_q, err_d;
  logic [31:0] fail_q, fail_d;
  logic        timeout_q, timeout_d;
  logic [31:0] adr_q, adr_d;

  logic        xfer;
  logic [31:0] pattern;
  logic [31:0] cur_adr;

  assign xfer    = (state_q == StWrite) || (state_q == StRead);
  assign pattern = seed_q + {22'b0, idx_q};
  assign cur_adr = ADDR_BASE + {20'b0, idx_q, 2'b00};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seed_d    = seed_q;
    wait_d    = wait_q;
    err_d     = err_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    // Address output holds the last transfer address between transfers.
    adr_d     = xfer ? cur_adr : adr_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          seed_d    = seed_i;
          idx_d     = '0;
          wait_d    = '0;
          err_d     = '0;
          fail_d    = '0;
          timeout_d = 1'b0;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        if (wbm_ack_i) begin
          state_d = StWgap;
        end else if (wait_q == WaitLast) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StWgap: begin
        wait_d = '0;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StRead;
        end else begin
          idx_d   = idx_q + 10'd1;
          state_d = StWrite;
        end
      end
      StRead: begin
        if (wbm_ack_i) begin
          if (wbm_dat_i != pattern) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            // err_q saturates and never returns to 0, so this only fires once.
            if (err_q == 16'd0) fail_d = cur_adr;
          end
          state_d = StRgap;
        end else if (wait_q == WaitLast) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StRgap: begin
        wait_d = '0;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 10'd1;
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      seed_q    <= '0;
      wait_q    <= '0;
      err_q     <= '0;
      fail_q    <= '0;
      timeout_q <= 1'b0;
      adr_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seed_q    <= seed_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      adr_q     <= adr_d;
    end
  end

  // Bus and status outputs decode directly from registered state, so a reset
  // edge drops cyc/stb immediately.
  assign wbm_cyc_o   = xfer;
  assign wbm_stb_o   = xfer;
  assign wbm_we_o    = (state_q == StWrite);
  assign wbm_sel_o   = 4'hF;
  assign wbm_adr_o   = xfer ? cur_adr : adr_q;
  assign wbm_dat_o   = (state_q == StWrite) ? pattern : 32'd0;
  assign busy_o      = (state_q == StWrite) || (state_q == StWgap) ||
                       (state_q == StRead)  || (state_q == StRgap);
  assign done_o      = (state_q == StDone);
  assign pass_o      = done_o && (err_q == 16'd0) && !timeout_q;
  assign timeout_o   = timeout_q;
  assign err_count_o = err_q;
  assign fail_adr_o  = fail_q;

endmodule

// File: tb/tb_wb_sram_bist_master.sv
module tb_wb_sram_bist_master;

  localparam logic [31:0] Base  = 32'h3000_0000;
  localparam int          Words = 4;
  localparam int          Tmo   = 8;

  logic        clk = 1'b0;
  logic        wb_rst_i, start_i;
  logic [31:0] seed_i;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [15:0] err_count_o;
  logic [31:0] fail_adr_o;

  always #5 clk = ~clk;

  wb_sram_bist_master #(
    .ADDR_BASE(Base),
    .WORDS    (Words),
    .TIMEOUT  (Tmo)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .start_i    (start_i),
    .seed_i     (seed_i),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_dat_i  (wbm_dat_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .timeout_o  (timeout_o),
    .err_count_o(err_count_o),
    .fail_adr_o (fail_adr_o)
  );

  // ---------------- memory model ----------------
  int          lat = 1;
  logic [3:0]  flip = 4'b0000;
  int          hang_idx = -1;
  int          stall_cnt = 0;
  logic [31:0] mem [4];
  logic [1:0]  widx;

  assign widx = wbm_adr_o[3:2];

  always_comb begin
    wbm_ack_i = wbm_cyc_o && wbm_stb_o && (stall_cnt == lat - 1);
    if (wbm_we_o && hang_idx == int'(widx)) wbm_ack_i = 1'b0;
    wbm_dat_i = mem[widx] ^ {31'b0, flip[widx]};
  end

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && wbm_we_o) mem[widx] <= wbm_dat_o;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xf_t;

  typedef struct {
    logic [15:0] err;
    logic [31:0] fail;
    logic        pass;
    logic        to;
    int          dur;
  } st_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [15:0] err;
    logic [31:0] fail;
  } rs_t;

  xf_t   exp_q[$];
  st_t   st_q[$];
  rs_t   rst_q[$];
  string wd_q[$];

  // Hand-computed table for seed 32'hFFFF_FFFE, ADDR_BASE 32'h3000_0000.
  logic [31:0] exp_w [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
  logic [31:0] exp_a [4] = '{32'h3000_0000, 32'h3000_0004, 32'h3000_0008, 32'h3000_000C};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic rst_seen = 1'b0;
  always @(posedge clk) rst_seen <= wb_rst_i;

  int   cyc_cnt = 0, t0 = 0, stb_run = 0, low_run = 0;
  logic prev_stb = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, prev_ack = 1'b0;

  always @(negedge clk) begin
    xf_t x;
    st_t s;
    rs_t r;
    cyc_cnt++;
    while (wd_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got no event expected event within cycle budget", wd_q.pop_front());
    end
    if (rst_seen) begin
      if (rst_q.size() != 0) begin
        r = rst_q.pop_front();
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_we", 32'(wbm_we_o), 32'd0);
        chk("rst_sel", 32'(wbm_sel_o), 32'(r.sel));
        chk("rst_adr", wbm_adr_o, r.adr);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_pass", 32'(pass_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_err", 32'(err_count_o), 32'(r.err));
        chk("rst_fail", fail_adr_o, r.fail);
        exp_q.delete();  // reset discards the interrupted run
      end
      stb_run = 0;
    end else begin
      if (wbm_stb_o && !prev_busy) t0 = cyc_cnt;
      if (wbm_stb_o && !prev_stb && prev_busy) chk("gap_len", 32'(low_run), 32'd1);
      if (wbm_stb_o) low_run = 0;
      else if (busy_o) low_run++;
      if (wbm_stb_o) stb_run++;
      if (wbm_stb_o && wbm_ack_i) begin
        chk("stb_len", 32'(stb_run), 32'(lat));
        stb_run = 0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer: got we=%b adr=%h expected none", wbm_we_o, wbm_adr_o);
        end else begin
          x = exp_q.pop_front();
          chk("xfer_we", 32'(wbm_we_o), 32'(x.we));
          chk("xfer_adr", wbm_adr_o, x.adr);
          if (x.we) chk("xfer_wdat", wbm_dat_o, x.dat);
        end
      end
      if (!wbm_stb_o && prev_stb && !prev_ack) chk("stall_len", 32'(stb_run), 32'(Tmo));
      if (!wbm_stb_o) stb_run = 0;
      if (done_o && !prev_done) begin
        if (st_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else begin
          s = st_q.pop_front();
          chk("done_err", 32'(err_count_o), 32'(s.err));
          chk("done_fail_adr", fail_adr_o, s.fail);
          chk("done_pass", 32'(pass_o), 32'(s.pass));
          chk("done_timeout", 32'(timeout_o), 32'(s.to));
          chk("done_busy", 32'(busy_o), 32'd0);
          chk("xfers_drained", 32'(exp_q.size()), 32'd0);
          if (s.dur >= 0) chk("duration", 32'(cyc_cnt - t0), 32'(s.dur));
        end
      end
    end
    prev_stb  = wbm_stb_o;
    prev_busy = busy_o;
    prev_done = done_o;
    prev_ack  = wbm_stb_o && wbm_ack_i;
  end

  // ---------------- stimulus ----------------
  task automatic push_xfers(input int nw, input int nr);
    for (int i = 0; i < nw; i++) exp_q.push_back('{we: 1'b1, adr: exp_a[i], dat: exp_w[i]});
    for (int i = 0; i < nr; i++) exp_q.push_back('{we: 1'b0, adr: exp_a[i], dat: 32'd0});
  endtask

  task automatic push_status(input logic [15:0] err, input logic [31:0] fail, input logic pass,
                             input logic to, input int dur);
    st_t s;
    s.err = err; s.fail = fail; s.pass = pass; s.to = to; s.dur = dur;
    st_q.push_back(s);
  endtask

  task automatic do_reset();
    rst_q.push_back('{sel: 4'hF, adr: 32'd0, err: 16'd0, fail: 32'd0});
    wb_rst_i = 1'b1;
    repeat (2) @(negedge clk);
    wb_rst_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    seed_i  = 32'hFFFF_FFFE;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) wd_q.push_back(name);
    @(negedge clk);
  endtask

  initial begin
    wb_rst_i = 1'b0;
    start_i  = 1'b0;
    seed_i   = 32'd0;
    do_reset();

    // Clean run, 1-cycle ack.
    push_xfers(4, 4);
    push_status(16'd0, 32'd0, 1'b1, 1'b0, 16);
    pulse_start();
    wait_done("done_clean");

    // Bit 0 flipped on words 1 and 3; restarted directly from DONE.
    flip = 4'b1010;
    push_xfers(4, 4);
    push_status(16'd2, 32'h3000_0004, 1'b0, 1'b0, 16);
    pulse_start();
    wait_done("done_flip");
    flip = 4'b0000;

    // 3-cycle ack latency.
    lat = 3;
    push_xfers(4, 4);
    push_status(16'd0, 32'd0, 1'b1, 1'b0, 32);
    pulse_start();
    wait_done("done_lat3");
    lat = 1;

    // Responder hangs on write word 2.
    hang_idx = 2;
    push_xfers(2, 0);
    push_status(16'd0, 32'd0, 1'b0, 1'b1, -1);
    pulse_start();
    wait_done("done_timeout");
    hang_idx = -1;

    // Second start (different seed) while busy must be ignored.
    push_xfers(4, 4);
    push_status(16'd0, 32'd0, 1'b1, 1'b0, 16);
    pulse_start();
    @(negedge clk);
    seed_i  = 32'h1234_5678;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("done_restart_ignored");

    // Reset while reading word 1 of a run that already mismatched word 0.
    flip = 4'b0001;
    push_xfers(4, 4);
    pulse_start();
    begin
      int n = 0;
      while (!(wbm_stb_o && !wbm_we_o && wbm_adr_o == 32'h3000_0004) && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) wd_q.push_back("read_word1_seen");
    end
    do_reset();
    flip = 4'b0000;
    push_xfers(4, 4);
    push_status(16'd0, 32'd0, 1'b1, 1'b0, 16);
    pulse_start();
    wait_done("done_after_reset");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
